// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Holds the funct3 op encodings, the 2-bit FSM state type and the fixed
// results for divide-by-zero and signed-overflow.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;  // quotient for x/0
  localparam logic [31:0] OVF_Q      = 32'h8000_0000;  // INT_MIN / -1
  localparam logic [31:0] OVF_R      = 32'h0000_0000;  // INT_MIN % -1
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  localparam logic [31:0] MINUS_ONE  = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative multiply/divide datapath (combinational).
// Ports: div_mode selects restoring divide vs shift-add multiply; part_i is the
// 64-bit partial ({hi, lo}); opnd_i the magnitude of b; part_o/qbit_o the next partial and quotient bit.
module mdu_step
  import mdu_pkg::*;
(
  input  logic        div_mode,
  input  logic [63:0] part_i,
  input  logic [31:0] opnd_i,
  output logic [63:0] part_o,
  output logic        qbit_o
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  always_comb begin
    // Multiply: hi accumulates b when the current multiplier bit (lo[0]) is set,
    // then the whole {carry, hi, lo} shifts right one place.
    sum    = {1'b0, part_i[63:32]} + {1'b0, opnd_i};
    // Divide: remainder shifted left with the next dividend bit brought in.
    rem_sh = part_i[63:31];
    diff   = rem_sh - {1'b0, opnd_i};
    qbit_o = 1'b0;
    part_o = part_i;
    if (div_mode) begin
      // A set bit 32 of rem_sh already exceeds any 32-bit divisor; otherwise
      // bit 32 of the difference is the borrow.
      qbit_o = rem_sh[32] | ~diff[32];
      // Quotient bit is left as 0 in the lsb and merged by the caller.
      part_o = {(qbit_o ? diff[31:0] : rem_sh[31:0]), part_i[30:0], 1'b0};
    end else if (part_i[0]) begin
      part_o = {sum, part_i[31:1]};
    end else begin
      part_o = {1'b0, part_i[63:1]};
    end
  end

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: 32 iterations + sign fix, result registered.
// Ports: in_valid/in_ready request handshake with funct3/a/b; out_valid/out_ready/out
// result handshake; busy high whenever not idle. Special divide cases finish in one cycle.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        busy
);

  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        neg_q, neg_d;
  logic [31:0] out_q, out_d;

  logic        signed_a, signed_b, sa, sb;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, div_ovf;
  logic [63:0] step_part;
  logic        step_qbit;
  logic [63:0] prod_fix;
  logic [31:0] div_sel;

  mdu_step u_step (
    .div_mode (op_q[2]),
    .part_i   (acc_q),
    .opnd_i   (opnd_q),
    .part_o   (step_part),
    .qbit_o   (step_qbit)
  );

  always_comb begin
    signed_a = (funct3 == MDU_MULH) || (funct3 == MDU_MULHSU) ||
               (funct3 == MDU_DIV)  || (funct3 == MDU_REM);
    signed_b = (funct3 == MDU_MULH) || (funct3 == MDU_DIV) || (funct3 == MDU_REM);
    sa       = signed_a & a[31];
    sb       = signed_b & b[31];
    a_mag    = sa ? (~a + 32'd1) : a;
    b_mag    = sb ? (~b + 32'd1) : b;
    div_zero = funct3[2] && (b == 32'd0);
    // Only the signed ops (DIV, REM: funct3[0]==0) can overflow.
    div_ovf  = funct3[2] && !funct3[0] && (a == INT_MIN) && (b == MINUS_ONE);

    prod_fix = neg_q ? (~acc_q + 64'd1) : acc_q;
    // After the last divide step hi holds the remainder, lo the quotient.
    div_sel  = op_q[1] ? acc_q[63:32] : acc_q[31:0];
    if (neg_q) div_sel = ~div_sel + 32'd1;

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    neg_d   = neg_q;
    out_d   = out_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d    = funct3;
          acc_d   = {32'd0, a_mag};
          opnd_d  = b_mag;
          // Remainder takes the dividend's sign; everything else sa^sb.
          neg_d   = (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
          cnt_d   = 5'd0;
          state_d = ST_CALC;
          if (div_zero) begin
            out_d   = funct3[1] ? a : DIV_ZERO_Q;
            state_d = ST_DONE;
          end else if (div_ovf) begin
            out_d   = funct3[1] ? OVF_R : OVF_Q;
            state_d = ST_DONE;
          end
        end
      end
      ST_CALC: begin
        acc_d = step_part | {63'd0, step_qbit};
        cnt_d = cnt_q + 5'd1;  // wraps to 0 leaving the last iteration
        if (cnt_q == 5'd31) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (op_q[2])               out_d = div_sel;
        else if (op_q == MDU_MUL)  out_d = prod_fix[31:0];
        else                       out_d = prod_fix[63:32];
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 3'd0;
      acc_q   <= 64'd0;
      opnd_q  <= 32'd0;
      neg_q   <= 1'b0;
      out_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out       = out_q;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_acc = 0;

  mdu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: RV32M semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q;
    logic [63:0] ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (f)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * longint'(uy)); return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sx / sy; return q[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        q = sx % sy; return q[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return f[2] && ((y == 0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Issue one op at a negedge with in_ready high, check latency, busy, result,
  // hold the result for rdy_dly cycles (optionally poking in_valid), then retire.
  task automatic do_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input int rdy_dly, input bit poke, input string name);
    logic [31:0] exp;
    int          exp_lat, k, guard;
    exp     = ref_model(f, x, y);
    exp_lat = is_special(f, x, y) ? 1 : 34;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    vectors++;
    if (guard >= 100) begin
      miscompares++; $display("FAIL %s in_ready_timeout got=%b want=1", name, in_ready);
    end
    in_valid = 1'b1; funct3 = f; a = x; b = y;
    @(posedge clk); last_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0; funct3 = 3'($urandom); a = $urandom; b = $urandom;
    k = 1;
    while (out_valid !== 1'b1 && k < 60) begin
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++; $display("FAIL %s busy_k%0d got=%b want=1", name, k, busy);
      end
      if (k == 5) begin in_valid = 1'b1; end  // ignored while busy
      if (k == 6) begin in_valid = 1'b0; end
      @(negedge clk); k++;
    end
    vectors++;
    if (k != exp_lat) begin
      miscompares++; $display("FAIL %s latency got=%0d want=%0d", name, k, exp_lat);
    end
    vectors++;
    if (out !== exp) begin
      miscompares++; $display("FAIL %s result got=%h want=%h (f=%0d a=%h b=%h)", name, out, exp, f, x, y);
    end
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL %s done_flags busy=%b in_ready=%b want 1/0", name, busy, in_ready);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      if (poke) begin in_valid = 1'b1; funct3 = 3'($urandom); a = $urandom; b = $urandom; end
      @(negedge clk);
      vectors++;
      if (out !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s hold_%0d out=%h want=%h out_valid=%b want=1 in_ready=%b want=0",
                 name, i, out, exp, out_valid, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s retire in_ready=%b out_valid=%b busy=%b want 1/0/0", name, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset out_valid=%b out=%h busy=%b in_ready=%b want 0/0/0/1", out_valid, out, busy, in_ready);
    end
  endtask

  task automatic test_mul();
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0, "mul_7_m3");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1, 0, "mulh_min");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "mulhu_max");
    do_op(3'd2, 32'hFFFF_FFFF, 32'd2, 2, 0, "mulhsu_m1_2");
  endtask

  task automatic test_div();
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_m7_2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, "rem_m7_2");
    do_op(3'd5, 32'd100, 32'd7, 0, 0, "divu_100_7");
    do_op(3'd7, 32'd100, 32'd7, 0, 0, "remu_100_7");
  endtask

  task automatic test_special();
    do_op(3'd5, 32'd5, 32'd0, 0, 0, "divu_by0");
    do_op(3'd6, 32'd5, 32'd0, 0, 0, "rem_by0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "rem_ovf");
  endtask

  task automatic test_backpressure();
    do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10, 1, "backpressure");
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_idle busy=%b in_ready=%b want 0/1", busy, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int first;
    do_op(3'd0, 32'd11, 32'd13, 0, 0, "b2b_0");
    first = last_acc;
    do_op(3'd5, 32'd1000, 32'd9, 0, 0, "b2b_1");
    vectors++;
    if (last_acc - first != 35) begin
      miscompares++; $display("FAIL b2b_spacing got=%0d want=35", last_acc - first);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    in_valid = 1'b1; funct3 = 3'd0; a = 32'd3; b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (k < 10) begin @(negedge clk); k++; end
    vectors++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL midrst_calc busy=%b out_valid=%b want 1/0", busy, out_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_idle out_valid=%b out=%h in_ready=%b busy=%b want 0/0/1/0", out_valid, out, in_ready, busy);
    end
    do_op(3'd0, 32'd3, 32'd5, 0, 0, "midrst_mul_3_5");
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] x, y;
    for (int n = 0; n < 40; n++) begin
      f = 3'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: begin x = 32'($urandom_range(0, 200)); y = 32'($urandom_range(1, 20)); end
        3: y = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      do_op(f, x, y, $urandom_range(0, 3), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
